peak_stimulus_gen: RTL and testbench
====================================

PEAK_STIMULUS_GEN -- requirements
Module: peak_stimulus_gen

Interface
REQ-001 Parameter DATA_OUT_BITS, default 16, SHALL set the sample width.
REQ-002 Parameter NUM_PEAKS, default 4 (power of two), SHALL set the number of peak-table entries.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin generation; ignored while busy.
REQ-006 stop  input  1  SHALL be a one-cycle request to finish the current peak, then idle.
REQ-007 enable  input  1  SHALL advance generation when 1; all state holds when 0.
REQ-008 step  input  DATA_OUT_BITS  SHALL be the ramp increment, sampled on an accepted start.
REQ-009 floor_value  input  DATA_OUT_BITS  SHALL be the trough level, sampled on an accepted start.
REQ-010 load  input  1  SHALL write load_value into peak-table entry load_addr on the clock edge.
REQ-011 load_addr  input  log2(NUM_PEAKS)  SHALL be the table write index.
REQ-012 load_value  input  DATA_OUT_BITS  SHALL be the peak height to write.
REQ-013 output_data  output  DATA_OUT_BITS  SHALL be the registered generated sample stream.
REQ-014 peak_flag  output  1  SHALL be high exactly in the cycle output_data holds a peak.
REQ-015 peak_count  output  8  SHALL count emitted peaks, wrapping 255->0.
REQ-016 busy  output  1  SHALL be high in states RISE and FALL.

Function
REQ-017 States SHALL be IDLE, RISE, FALL.
REQ-018 IDLE: accepted start SHALL latch step (0 treated as 1) and floor_value, set table index to 0, load output_data with floor, and enter RISE.
REQ-019 RISE: with sum = output_data + step computed in DATA_OUT_BITS+1 bits, if sum >= table[index] then output_data <= table[index], peak_flag <= 1, peak_count increments, state <= FALL; else output_data <= sum.
REQ-020 RISE: a table entry <= floor SHALL be skipped in its first RISE cycle (no peak, no count), with index advancing and output_data held.
REQ-021 FALL: if output_data < floor + step (DATA_OUT_BITS+1 bits) then output_data <= floor and index increments modulo NUM_PEAKS; otherwise output_data <= output_data - step.
REQ-022 At the FALL->floor transition, the state SHALL go to IDLE if stop is pending, else RISE.
REQ-023 stop SHALL be captured into a pending flag while busy and cleared on entry to IDLE; stop in IDLE SHALL have no effect.
REQ-024 Table writes SHALL be accepted in any state and take effect from the next cycle, including a write to the entry currently in use.
REQ-025 When enable is 0, output_data, state, index and counters SHALL hold, and peak_flag SHALL be 0; start, stop and load SHALL still be accepted.
REQ-026 Sample-to-sample latency SHALL be one cycle, and a strict peak SHALL always be followed by a strictly lower sample.

Reset
REQ-027 Reset SHALL force IDLE, output_data=0, peak_flag=0, peak_count=0, busy=0, index=0, pending stop=0, and all table entries=0, immediately and regardless of state.

Structure
REQ-028 State encodings SHALL live in a shared include header alongside the other peak-processing constants.
REQ-029 The peak table SHALL be a sub-module peak_table_regs (write port plus combinational read port); all other logic SHALL stay in the top module.

Verification
REQ-030 Setup: floor=0, step=10, table={35,35,35,35}; start -> output_data 0,10,20,30,35(flag),25,15,5,0,10,...; peak_count=1 after the first peak.
REQ-031 Setup: floor=0, step=0x8000, table[0]=0xFFFF -> output_data 0,0x8000,0xFFFF(flag) with no wrap, then 0x7FFF, then floor 0.
REQ-032 Setup: table={50,5,50,50}, floor=10, step=10 -> the first peak is 50, entry 1 is skipped without a flag, and the next peak is 50.
REQ-033 Stop during RISE of the first peak -> the peak completes, output_data returns to floor, busy falls, and output_data holds at floor.
REQ-034 enable=0 for 3 cycles mid-RISE at output_data=20 -> output_data holds at 20, then resumes at 30.
REQ-035 Reset asserted mid-FALL -> outputs are 0 in the same cycle and the table is cleared; a start after reset with an all-zero table never raises peak_flag.

Source files
------------

// File: rtl/peak_stimulus_gen_pkg.sv
// Shared constants for the peak stimulus generator: FSM encoding,
// counter width and the table index-width helper.
package peak_stimulus_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } gen_state_e;

  localparam int PEAK_COUNT_BITS = 8;

  // Index width for an N-entry table, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/peak_stimulus_gen_table_regs.sv
// Peak-height table: one synchronous write port, one combinational read port,
// every entry cleared by reset.
module peak_table_regs
  import peak_stimulus_gen_pkg::*;
#(
  parameter int DATA_BITS   = 16,
  parameter int NUM_ENTRIES = 4,
  localparam int AW = idx_bits(NUM_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem_q [NUM_ENTRIES];
  logic [DATA_BITS-1:0] mem_d [NUM_ENTRIES];

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign mem_d[gi] = (we && (waddr == AW'(gi))) ? wdata : mem_q[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/peak_stimulus_gen.sv
// Ramp-up / ramp-down stimulus generator that climbs from a floor to each
// programmed peak height in turn, then descends back to the floor.
module peak_stimulus_gen
  import peak_stimulus_gen_pkg::*;
#(
  parameter int DATA_OUT_BITS = 16,
  parameter int NUM_PEAKS     = 4,
  localparam int IDX_BITS = idx_bits(NUM_PEAKS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       enable,
  input  logic [DATA_OUT_BITS-1:0]   step,
  input  logic [DATA_OUT_BITS-1:0]   floor_value,
  input  logic                       load,
  input  logic [IDX_BITS-1:0]        load_addr,
  input  logic [DATA_OUT_BITS-1:0]   load_value,
  output logic [DATA_OUT_BITS-1:0]   output_data,
  output logic                       peak_flag,
  output logic [PEAK_COUNT_BITS-1:0] peak_count,
  output logic                       busy
);

  localparam int W = DATA_OUT_BITS;
  localparam logic [W-1:0] STEP_MIN = W'(1);

  gen_state_e                 state_q, state_d;
  logic [W-1:0]               out_q, out_d;
  logic                       flag_q, flag_d;
  logic [PEAK_COUNT_BITS-1:0] count_q, count_d;
  logic [IDX_BITS-1:0]        idx_q, idx_d;
  logic [W-1:0]               step_q, step_d;
  logic [W-1:0]               floor_q, floor_d;
  logic                       pend_q, pend_d;
  logic                       busy_q, busy_d;

  logic [W-1:0] peak_val;
  logic [W:0]   rise_sum;
  logic [W:0]   fall_thr;

  peak_table_regs #(
    .DATA_BITS   (W),
    .NUM_ENTRIES (NUM_PEAKS)
  ) u_table (
    .clk   (clk),
    .rst   (reset),
    .we    (load),
    .waddr (load_addr),
    .wdata (load_value),
    .raddr (idx_q),
    .rdata (peak_val)
  );

  // One extra bit so a ramp near full scale clamps to the peak instead of wrapping.
  assign rise_sum = {1'b0, out_q} + {1'b0, step_q};
  assign fall_thr = {1'b0, floor_q} + {1'b0, step_q};

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flag_d  = 1'b0;
    count_d = count_q;
    idx_d   = idx_q;
    step_d  = step_q;
    floor_d = floor_q;
    pend_d  = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          step_d  = (step == '0) ? STEP_MIN : step;
          floor_d = floor_value;
          idx_d   = '0;
          out_d   = floor_value;
          state_d = ST_RISE;
        end
      end

      ST_RISE: begin
        if (stop) begin
          pend_d = 1'b1;
        end
        if (enable) begin
          if (peak_val <= floor_q) begin
            // An entry at or below the floor can never form a strict peak.
            idx_d = idx_q + 1'b1;
          end else if (rise_sum >= {1'b0, peak_val}) begin
            out_d   = peak_val;
            flag_d  = 1'b1;
            count_d = count_q + 1'b1;
            state_d = ST_FALL;
          end else begin
            out_d = rise_sum[W-1:0];
          end
        end
      end

      ST_FALL: begin
        if (stop) begin
          pend_d = 1'b1;
        end
        if (enable) begin
          if ({1'b0, out_q} < fall_thr) begin
            out_d = floor_q;
            idx_d = idx_q + 1'b1;
            if (pend_q || stop) begin
              state_d = ST_IDLE;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_RISE;
            end
          end else begin
            out_d = out_q - step_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      flag_q  <= 1'b0;
      count_q <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      floor_q <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
    end
  end

  assign output_data = out_q;
  assign peak_flag   = flag_q;
  assign peak_count  = count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_peak_stimulus_gen.sv
// Scoreboard bench for peak_stimulus_gen: directed scenarios plus random traffic
// checked against a behavioural model of the ramp/peak rules.
module tb_peak_stimulus_gen;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stop, enable, load;
  logic [W-1:0]  step, floor_value, load_value;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  output_data;
  logic          peak_flag;
  logic [7:0]    peak_count;
  logic          busy;

  always #5 clk = ~clk;

  peak_stimulus_gen #(.DATA_OUT_BITS(W), .NUM_PEAKS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .enable      (enable),
    .step        (step),
    .floor_value (floor_value),
    .load        (load),
    .load_addr   (load_addr),
    .load_value  (load_value),
    .output_data (output_data),
    .peak_flag   (peak_flag),
    .peak_count  (peak_count),
    .busy        (busy)
  );

  typedef struct {
    logic [W-1:0] out;
    logic         flag;
    logic [7:0]   cnt;
    logic         busy;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   txn         = 0;

  // Behavioural model: phase 0 = idle, 1 = climbing, 2 = descending.
  int m_phase, m_out, m_flag, m_cnt, m_idx, m_step, m_floor, m_pend;
  int m_tab[N];

  task automatic model_reset();
    m_phase = 0; m_out = 0; m_flag = 0; m_cnt = 0; m_idx = 0;
    m_step = 0; m_floor = 0; m_pend = 0;
    for (int i = 0; i < N; i++) m_tab[i] = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit en, input bit ld,
                            input int la, input int lv, input int stp, input int flr);
    int n_phase = m_phase;
    int n_out   = m_out;
    int n_cnt   = m_cnt;
    int n_idx   = m_idx;
    int n_pend  = m_pend;
    int n_flag  = 0;
    int height;
    if (m_phase == 0) begin
      if (st) begin
        m_step  = (stp == 0) ? 1 : stp;
        m_floor = flr;
        n_idx   = 0;
        n_out   = flr;
        n_phase = 1;
      end
    end else begin
      if (sp) n_pend = 1;
      if (en) begin
        if (m_phase == 1) begin
          height = m_tab[m_idx];
          if (height <= m_floor) begin
            n_idx = (m_idx + 1) % N;
          end else if (m_out + m_step >= height) begin
            n_out   = height;
            n_flag  = 1;
            n_cnt   = (m_cnt + 1) % 256;
            n_phase = 2;
          end else begin
            n_out = m_out + m_step;
          end
        end else begin
          if (m_out < m_floor + m_step) begin
            n_out = m_floor;
            n_idx = (m_idx + 1) % N;
            if (m_pend != 0 || sp) begin
              n_phase = 0;
              n_pend  = 0;
            end else begin
              n_phase = 1;
            end
          end else begin
            n_out = m_out - m_step;
          end
        end
      end
    end
    if (ld) m_tab[la] = lv;
    m_phase = n_phase; m_out = n_out; m_flag = n_flag; m_cnt = n_cnt;
    m_idx = n_idx; m_pend = n_pend;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Apply one clock of stimulus, predict the response, return at the next negedge.
  task automatic cycle(input bit st, input bit sp, input bit en, input bit ld = 1'b0,
                       input int la = 0, input int lv = 0, input int stp = 0, input int flr = 0);
    exp_t e;
    start = st; stop = sp; enable = en; load = ld;
    load_addr = la[AW-1:0]; load_value = lv[W-1:0];
    step = stp[W-1:0]; floor_value = flr[W-1:0];
    if (reset) model_reset();
    else model_step(st, sp, en, ld, la, lv, stp, flr);
    e.out  = m_out[W-1:0];
    e.flag = (m_flag != 0);
    e.cnt  = m_cnt[7:0];
    e.busy = (m_phase != 0);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_all(input int v0, input int v1, input int v2, input int v3);
    cycle(0, 0, 1, 1, 0, v0);
    cycle(0, 0, 1, 1, 1, v1);
    cycle(0, 0, 1, 1, 2, v2);
    cycle(0, 0, 1, 1, 3, v3);
  endtask

  task automatic drain(input string nm);
    int left = 60;
    cycle(0, 1, 1);
    while (m_phase != 0 && left > 0) begin
      cycle(0, 0, 1);
      left--;
    end
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: one pop and compare per clock in which a prediction is outstanding.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      txn++;
      vectors++;
      $display("txn %0d out=%0h flag=%0b cnt=%0d busy=%0b", txn, output_data, peak_flag,
               peak_count, busy);
      if (output_data !== e.out || peak_flag !== e.flag || peak_count !== e.cnt ||
          busy !== e.busy) begin
        miscompares++;
        $display("FAIL sb_txn%0d: got out=%0h flag=%0b cnt=%0d busy=%0b want out=%0h flag=%0b cnt=%0d busy=%0b",
                 txn, output_data, peak_flag, peak_count, busy, e.out, e.flag, e.cnt, e.busy);
      end
    end
  end

  int e30[9] = '{10, 20, 30, 35, 25, 15, 5, 0, 10};
  int e31[4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 0};
  int e32[14] = '{20, 30, 40, 50, 40, 30, 20, 10, 10, 10, 20, 30, 40, 50};

  initial begin
    reset = 1'b1; start = 0; stop = 0; enable = 0; load = 0;
    load_addr = '0; load_value = '0; step = '0; floor_value = '0;
    model_reset();
    #1;
    chk("rst_out", {16'd0, output_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    reset = 1'b0;

    // Basic ramp to 35 and back
    load_all(35, 35, 35, 35);
    cycle(1, 0, 1, 0, 0, 0, 10, 0);
    chk("r30_out0", {16'd0, output_data}, 32'd0);
    foreach (e30[i]) begin
      cycle(0, 0, 1);
      chk($sformatf("r30_out%0d", i + 1), {16'd0, output_data}, e30[i]);
      chk($sformatf("r30_flag%0d", i + 1), {31'd0, peak_flag}, (e30[i] == 35) ? 1 : 0);
    end
    chk("r30_count", {24'd0, peak_count}, 32'd1);
    drain("r30");

    // Full-scale peak, no wrap on the ramp
    cycle(0, 0, 1, 1, 0, 16'hFFFF);
    cycle(1, 0, 1, 0, 0, 0, 16'h8000, 0);
    chk("r31_out0", {16'd0, output_data}, 32'd0);
    foreach (e31[i]) begin
      cycle(0, 0, 1);
      chk($sformatf("r31_out%0d", i + 1), {16'd0, output_data}, e31[i]);
    end
    drain("r31");

    // Entry below the floor is skipped
    load_all(50, 5, 50, 50);
    cycle(1, 0, 1, 0, 0, 0, 10, 10);
    chk("r32_out0", {16'd0, output_data}, 32'd10);
    foreach (e32[i]) begin
      cycle(0, 0, 1);
      chk($sformatf("r32_out%0d", i + 1), {16'd0, output_data}, e32[i]);
      chk($sformatf("r32_flag%0d", i + 1), {31'd0, peak_flag}, (i == 3 || i == 13) ? 1 : 0);
    end
    drain("r32");

    // Stop during the first climb
    load_all(50, 50, 50, 50);
    cycle(1, 0, 1, 0, 0, 0, 10, 0);
    cycle(0, 0, 1);
    cycle(0, 1, 1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 1);
    chk("r33_busy", {31'd0, busy}, 32'd0);
    chk("r33_out", {16'd0, output_data}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1);
    chk("r33_hold", {16'd0, output_data}, 32'd0);

    // Enable gap mid-climb
    cycle(1, 0, 1, 0, 0, 0, 10, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      chk($sformatf("r34_hold%0d", i), {16'd0, output_data}, 32'd20);
    end
    cycle(0, 0, 1);
    chk("r34_resume", {16'd0, output_data}, 32'd30);

    // Asynchronous reset mid-descent
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("r35_in_fall", {16'd0, output_data}, 32'd40);
    reset = 1'b1;
    #1;
    chk("r35_out", {16'd0, output_data}, 32'd0);
    chk("r35_flag", {31'd0, peak_flag}, 32'd0);
    chk("r35_count", {24'd0, peak_count}, 32'd0);
    chk("r35_busy", {31'd0, busy}, 32'd0);
    model_reset();
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    reset = 1'b0;
    cycle(1, 0, 1, 0, 0, 0, 7, 0);
    for (int i = 0; i < 30; i++) begin
      cycle(0, 0, 1);
      chk($sformatf("r35_noflag%0d", i), {31'd0, peak_flag}, 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit st, sp, en, ld;
      int la, lv, stp, flr;
      st  = ($urandom_range(0, 15) == 0);
      sp  = ($urandom_range(0, 40) == 0);
      en  = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 7) == 0);
      la  = $urandom_range(0, N - 1);
      lv  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 300);
      stp = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 40);
      flr = $urandom_range(0, 100);
      cycle(st, sp, en, ld, la, lv, stp, flr);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
